// File: rtl/hamming_rx_ctrl_if.sv
// ----------------------------------------------------------------------------
// hamming_rx_ctrl_if
// Channel-side bit stream and sink-side byte stream of the (7,4) Hamming
// receive controller.
//   bit_i / bit_valid_i / sof_i / bit_ready_o : serial codeword bits, c0 first
//   byte_o / byte_valid_o / byte_ready_i      : packed decoded bytes
// slave  : the controller's view
// master : the view of the environment driving the bits and sinking bytes
// ----------------------------------------------------------------------------
interface hamming_rx_ctrl_if;
    logic       bit_i;
    logic       bit_valid_i;
    logic       sof_i;
    logic       bit_ready_o;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i;

    modport slave (
        input  bit_i, bit_valid_i, sof_i, byte_ready_i,
        output bit_ready_o, byte_o, byte_valid_o
    );

    modport master (
        output bit_i, bit_valid_i, sof_i, byte_ready_i,
        input  bit_ready_o, byte_o, byte_valid_o
    );
endinterface

// File: rtl/hamming_rx_ctrl.sv
// ----------------------------------------------------------------------------
// hamming_rx_ctrl
// Receive-side controller for a (7,4) Hamming link. Frames the serial bit
// stream into codewords on sof_i, corrects single-bit errors, packs pairs of
// decoded nibbles into bytes and keeps saturating error statistics.
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          hamming_rx_ctrl_if.slave (bit input stream, byte output stream)
//   clr_stats_i  synchronous clear of the statistics counters
//   frag_err_o   one-cycle pulse when a partial codeword is dropped by sof_i
//   cw_cnt_o     codewords decoded
//   corr_cnt_o   codewords with a corrected data bit
//   par_cnt_o    codewords with a parity-bit-only error
// ----------------------------------------------------------------------------
module hamming_rx_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hamming_rx_ctrl_if.slave     bus,
    input  logic                 clr_stats_i,
    output logic                 frag_err_o,
    output logic [CNT_W-1:0]     cw_cnt_o,
    output logic [CNT_W-1:0]     corr_cnt_o,
    output logic [CNT_W-1:0]     par_cnt_o
);

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_bits;
    logic [2:0]       r_bit_cnt;
    logic             r_pend;
    logic [3:0]       r_low;
    logic [7:0]       r_byte;
    logic             r_byte_vld;
    logic             r_frag;
    logic [CNT_W-1:0] r_cw_cnt;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_par_cnt;

    logic             w_bit_ready;
    logic             w_accept;
    logic             w_start;
    logic             w_store;
    logic             w_complete;
    logic             w_frag;
    logic             w_load;
    logic [6:0]       w_cw;
    logic [2:0]       w_syn;
    logic [3:0]       w_nib;
    logic             w_corr_hit;
    logic             w_par_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stall only the bit that would complete a second nibble while the output
    // register still holds an unaccepted byte; everything else can proceed.
    assign w_bit_ready = ~((r_state == ST_COLLECT) && (r_bit_cnt == 3'd6) && r_pend
                           && r_byte_vld && ~bus.byte_ready_i);
    assign w_accept    = bus.bit_valid_i & w_bit_ready;

    // Completing codeword: the incoming bit is c6.
    assign w_cw     = {bus.bit_i, r_bits};
    assign w_syn[0] = w_cw[4] ^ w_cw[0] ^ w_cw[1] ^ w_cw[2];
    assign w_syn[1] = w_cw[5] ^ w_cw[0] ^ w_cw[2] ^ w_cw[3];
    assign w_syn[2] = w_cw[6] ^ w_cw[0] ^ w_cw[1] ^ w_cw[3];

    always_comb begin
        w_nib      = w_cw[3:0];
        w_corr_hit = 1'b0;
        w_par_hit  = 1'b0;
        case (w_syn)
            3'b111: begin w_nib[0] = ~w_cw[0]; w_corr_hit = 1'b1; end
            3'b101: begin w_nib[1] = ~w_cw[1]; w_corr_hit = 1'b1; end
            3'b011: begin w_nib[2] = ~w_cw[2]; w_corr_hit = 1'b1; end
            3'b110: begin w_nib[3] = ~w_cw[3]; w_corr_hit = 1'b1; end
            3'b001, 3'b010, 3'b100: w_par_hit = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_store     = 1'b0;
        w_complete  = 1'b0;
        w_frag      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && bus.sof_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    if (bus.sof_i && (r_bit_cnt != 3'd0)) begin
                        w_start = 1'b1;
                        w_frag  = 1'b1;
                    end else if (r_bit_cnt == 3'd6) begin
                        w_complete = 1'b1;
                    end else begin
                        w_store = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Second nibble of a pair turns into a byte on the output register.
    assign w_load = w_complete & r_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bits     <= '0;
            r_bit_cnt  <= '0;
            r_pend     <= 1'b0;
            r_low      <= '0;
            r_byte     <= '0;
            r_byte_vld <= 1'b0;
            r_frag     <= 1'b0;
            r_cw_cnt   <= '0;
            r_corr_cnt <= '0;
            r_par_cnt  <= '0;
        end else begin
            if (w_start) begin
                r_bits[0] <= bus.bit_i;
                r_bit_cnt <= 3'd1;
            end else if (w_store) begin
                r_bits[r_bit_cnt] <= bus.bit_i;
                r_bit_cnt         <= r_bit_cnt + 3'd1;
            end else if (w_complete) begin
                r_bit_cnt <= 3'd0;
            end

            r_frag <= w_frag;

            if (w_complete) begin
                if (r_pend) begin
                    r_byte <= {w_nib, r_low};
                    r_pend <= 1'b0;
                end else begin
                    r_low  <= w_nib;
                    r_pend <= 1'b1;
                end
            end

            // A byte loading on the handshake edge keeps valid asserted.
            if (w_load) begin
                r_byte_vld <= 1'b1;
            end else if (r_byte_vld && bus.byte_ready_i) begin
                r_byte_vld <= 1'b0;
            end

            if (clr_stats_i) begin
                r_cw_cnt   <= '0;
                r_corr_cnt <= '0;
                r_par_cnt  <= '0;
            end else if (w_complete) begin
                r_cw_cnt <= sat_inc(r_cw_cnt);
                if (w_corr_hit) r_corr_cnt <= sat_inc(r_corr_cnt);
                if (w_par_hit)  r_par_cnt  <= sat_inc(r_par_cnt);
            end
        end
    end

    assign bus.bit_ready_o  = w_bit_ready;
    assign bus.byte_o       = r_byte;
    assign bus.byte_valid_o = r_byte_vld;
    assign frag_err_o       = r_frag;
    assign cw_cnt_o         = r_cw_cnt;
    assign corr_cnt_o       = r_corr_cnt;
    assign par_cnt_o        = r_par_cnt;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hamming_rx_ctrl
// Bench for hamming_rx_ctrl: a queue-based reference model decodes codewords
// by matching the syndrome against the parity-check columns, and a compare
// process checks every output on every cycle. Directed sequences with literal
// expectations are followed by randomized traffic. Counters use a narrow
// width so saturation is reachable in a short run.
// ----------------------------------------------------------------------------
module tb_hamming_rx_ctrl;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_stats_i;
    logic          frag_err_o;
    logic [CW-1:0] cw_cnt_o, corr_cnt_o, par_cnt_o;

    always #5 clk = ~clk;

    hamming_rx_ctrl_if bus ();

    hamming_rx_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .clr_stats_i (clr_stats_i),
        .frag_err_o  (frag_err_o),
        .cw_cnt_o    (cw_cnt_o),
        .corr_cnt_o  (corr_cnt_o),
        .par_cnt_o   (par_cnt_o)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Parity-check column of each codeword position c0..c6, as {s2,s1,s0}.
    localparam logic [2:0] COL [7] = '{3'b111, 3'b101, 3'b011, 3'b110,
                                       3'b001, 3'b010, 3'b100};

    bit            m_coll;
    int            m_bits[$];
    bit            m_pend;
    logic [3:0]    m_low;
    logic [7:0]    m_byte;
    bit            m_bvld;
    bit            m_frag;
    logic [CW-1:0] m_cw, m_corr, m_par;
    bit            m_acc, m_loaded, m_frag_n, m_done, m_corr_ev, m_par_ev;
    logic [6:0]    m_word;
    logic [2:0]    m_syn;
    int            m_pos;

    function automatic logic [CW-1:0] msat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic bit m_ready();
        return !(m_coll && m_bits.size() == 6 && m_pend && m_bvld && !bus.byte_ready_i);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_coll = 0; m_bits.delete(); m_pend = 0; m_low = 0; m_byte = 0;
            m_bvld = 0; m_frag = 0; m_cw = 0; m_corr = 0; m_par = 0;
        end else begin
            m_acc = bus.bit_valid_i && m_ready();
            m_loaded = 0; m_frag_n = 0; m_done = 0; m_corr_ev = 0; m_par_ev = 0;
            if (m_acc) begin
                if (!m_coll) begin
                    if (bus.sof_i) begin
                        m_bits.delete(); m_bits.push_back(int'(bus.bit_i)); m_coll = 1;
                    end
                end else if (bus.sof_i && m_bits.size() != 0) begin
                    m_bits.delete(); m_bits.push_back(int'(bus.bit_i)); m_frag_n = 1;
                end else begin
                    m_bits.push_back(int'(bus.bit_i));
                    if (m_bits.size() == 7) begin
                        m_syn = 3'b000;
                        for (int i = 0; i < 7; i++) begin
                            m_word[i] = (m_bits[i] != 0);
                            if (m_word[i]) m_syn = m_syn ^ COL[i];
                        end
                        m_pos = -1;
                        for (int i = 0; i < 7; i++)
                            if (m_syn != 3'b000 && COL[i] == m_syn) m_pos = i;
                        if (m_pos >= 0) m_word[m_pos] = ~m_word[m_pos];
                        m_corr_ev = (m_pos >= 0 && m_pos < 4);
                        m_par_ev  = (m_pos >= 4);
                        m_done = 1;
                        m_bits.delete();
                        if (!m_pend) begin
                            m_low = m_word[3:0]; m_pend = 1;
                        end else begin
                            m_byte = {m_word[3:0], m_low}; m_pend = 0; m_loaded = 1;
                        end
                    end
                end
            end
            if (m_loaded) m_bvld = 1;
            else if (m_bvld && bus.byte_ready_i) m_bvld = 0;
            m_frag = m_frag_n;
            if (clr_stats_i) begin
                m_cw = 0; m_corr = 0; m_par = 0;
            end else if (m_done) begin
                m_cw = msat(m_cw);
                if (m_corr_ev) m_corr = msat(m_corr);
                if (m_par_ev)  m_par  = msat(m_par);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("bit_ready", 32'(bus.bit_ready_o), 32'(m_ready()));
            check("byte_valid", 32'(bus.byte_valid_o), 32'(m_bvld));
            check("byte_o", 32'(bus.byte_o), 32'(m_byte));
            check("frag_err", 32'(frag_err_o), 32'(m_frag));
            check("cw_cnt", 32'(cw_cnt_o), 32'(m_cw));
            check("corr_cnt", 32'(corr_cnt_o), 32'(m_corr));
            check("par_cnt", 32'(par_cnt_o), 32'(m_par));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[0] ^ d[1] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2], d};
    endfunction

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer one bit until accepted (bounded); caller is aligned at posedge+1.
    task automatic send_bit(input logic b, input logic s);
        int  waited = 0;
        bit  acc = 0;
        bus.bit_i = b; bus.sof_i = s; bus.bit_valid_i = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = bus.bit_ready_o;
            align();
            waited++;
        end
        bus.bit_valid_i = 1'b0; bus.sof_i = 1'b0;
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_cw(input logic [6:0] w, input bit with_sof);
        for (int i = 0; i < 7; i++) send_bit(w[i], with_sof && i == 0);
    endtask

    task automatic pulse_clr();
        clr_stats_i = 1'b1;
        align();
        clr_stats_i = 1'b0;
    endtask

    logic [6:0] cwv;
    logic [6:0] cwa;

    initial begin
        rst_n = 1'b0; clr_stats_i = 1'b0;
        bus.bit_i = 1'b0; bus.bit_valid_i = 1'b0; bus.sof_i = 1'b0; bus.byte_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_byte_valid", 32'(bus.byte_valid_o), 32'd0);
        check("rst_byte_o", 32'(bus.byte_o), 32'h00);
        check("rst_cw_cnt", 32'(cw_cnt_o), 32'd0);
        check("rst_bit_ready", 32'(bus.bit_ready_o), 32'd1);
        align();

        // Clean stream
        cwv = 7'b1001011; send_cw(cwv, 1);
        cwv = 7'b1010010; send_cw(cwv, 1);
        @(negedge clk);
        check("clean_byte", 32'(bus.byte_o), 32'h2B);
        check("clean_valid", 32'(bus.byte_valid_o), 32'd1);
        check("clean_cw", 32'(cw_cnt_o), 32'd2);
        check("clean_corr", 32'(corr_cnt_o), 32'd0);
        align();

        // Data-bit error (c0 flipped)
        pulse_clr();
        cwv = 7'b1001010; send_cw(cwv, 1);
        cwv = 7'b1010010; send_cw(cwv, 1);
        @(negedge clk);
        check("derr_byte", 32'(bus.byte_o), 32'h2B);
        check("derr_corr", 32'(corr_cnt_o), 32'd1);
        align();

        // Parity-bit error (c5 flipped)
        pulse_clr();
        cwv = 7'b1001011; send_cw(cwv, 1);
        cwv = 7'b1110010; send_cw(cwv, 1);
        @(negedge clk);
        check("perr_byte", 32'(bus.byte_o), 32'h2B);
        check("perr_par", 32'(par_cnt_o), 32'd1);
        check("perr_corr", 32'(corr_cnt_o), 32'd0);
        align();

        // Backpressure
        bus.byte_ready_i = 1'b0;
        send_cw(enc(4'hB), 1);
        send_cw(enc(4'h2), 1);
        send_cw(enc(4'h5), 1);
        cwa = enc(4'hA);
        for (int i = 0; i < 6; i++) send_bit(cwa[i], i == 0);
        bus.bit_i = cwa[6]; bus.sof_i = 1'b0; bus.bit_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(bus.bit_ready_o), 32'd0);
            check("bp_byte_hold", 32'(bus.byte_o), 32'h2B);
        end
        align();
        bus.byte_ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_high", 32'(bus.bit_ready_o), 32'd1);
        align();
        bus.bit_valid_i = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(bus.byte_valid_o), 32'd1);
        check("bp_next_byte", 32'(bus.byte_o), 32'hA5);
        align();

        // Resync after a 3-bit fragment
        pulse_clr();
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        cwv = enc(4'h7);
        send_bit(cwv[0], 1'b1);
        @(negedge clk);
        check("frag_pulse", 32'(frag_err_o), 32'd1);
        align();
        @(negedge clk);
        check("frag_clear", 32'(frag_err_o), 32'd0);
        align();
        for (int i = 1; i < 7; i++) send_bit(cwv[i], 1'b0);
        @(negedge clk);
        check("resync_cw", 32'(cw_cnt_o), 32'd1);
        check("resync_err", 32'(corr_cnt_o | par_cnt_o), 32'd0);
        align();

        // Reset mid-codeword with a byte pending at the output
        bus.byte_ready_i = 1'b0;
        send_cw(enc(4'hC), 1);
        cwv = enc(4'h9);
        for (int i = 0; i < 3; i++) send_bit(cwv[i], i == 0);
        rst_n = 1'b0;
        align();
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_valid", 32'(bus.byte_valid_o), 32'd0);
        check("mrst_byte", 32'(bus.byte_o), 32'h00);
        check("mrst_cw", 32'(cw_cnt_o), 32'd0);
        align();
        bus.byte_ready_i = 1'b1;
        send_cw(enc(4'h6), 0);
        send_cw(enc(4'h3), 0);
        @(negedge clk);
        check("nosof_valid", 32'(bus.byte_valid_o), 32'd0);
        check("nosof_cw", 32'(cw_cnt_o), 32'd0);
        align();

        // Saturation with forced data errors
        pulse_clr();
        for (int k = 0; k < 70; k++) begin
            cwv = enc(4'($urandom_range(0, 15))) ^ 7'b0000001;
            send_cw(cwv, 1);
        end
        @(negedge clk);
        check("sat_corr", 32'(corr_cnt_o), 32'h3F);
        check("sat_cw", 32'(cw_cnt_o), 32'h3F);
        check("sat_par", 32'(par_cnt_o), 32'd0);
        align();
        // Clear coinciding with a completion
        cwv = enc(4'h3) ^ 7'b0001000;
        for (int i = 0; i < 6; i++) send_bit(cwv[i], i == 0);
        clr_stats_i = 1'b1;
        send_bit(cwv[6], 1'b0);
        clr_stats_i = 1'b0;
        @(negedge clk);
        check("clr_cw", 32'(cw_cnt_o), 32'd0);
        check("clr_corr", 32'(corr_cnt_o), 32'd0);
        align();

        // Randomized raw traffic
        for (int n = 0; n < 4000; n++) begin
            bus.bit_i        = 1'($urandom_range(0, 1));
            bus.bit_valid_i  = ($urandom_range(0, 3) != 0);
            bus.sof_i        = ($urandom_range(0, 9) == 0);
            bus.byte_ready_i = ($urandom_range(0, 2) != 0);
            clr_stats_i      = ($urandom_range(0, 199) == 0);
            rst_n            = ($urandom_range(0, 699) != 0);
            align();
        end
        bus.bit_valid_i = 1'b0; bus.sof_i = 1'b0; clr_stats_i = 1'b0; rst_n = 1'b1;
        align();

        // Randomized aligned codewords with zero or one bit error
        for (int k = 0; k < 300; k++) begin
            cwv = enc(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) != 0) cwv[$urandom_range(0, 6)] ^= 1'b1;
            bus.byte_ready_i = 1'($urandom_range(0, 1));
            for (int i = 0; i < 6; i++) send_bit(cwv[i], i == 0);
            bus.byte_ready_i = 1'b1;
            send_bit(cwv[6], 1'b0);
        end
        repeat (3) align();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_rx_ctrl.md
Name: hamming_rx_ctrl

Overview:
- Receive-side controller for the (7,4) Hamming link.
- Frames a serial channel bit stream into 7-bit codewords using a start-of-codeword marker, and decodes each codeword with single-bit correction.
- Packs decoded nibbles into bytes and presents them on a valid/ready interface, with backpressure to the channel side.
- Keeps saturating error statistics for the link BER monitor.

Parameters:
CNT_W, 16, width of each statistics counter (saturating)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
bit_i  in  1  channel bit
bit_valid_i  in  1  bit_i qualifier
sof_i  in  1  marks bit_i as c0 (first bit) of a codeword; sampled only with bit_valid_i
bit_ready_o  out  1  controller can accept bit_i this cycle
byte_o  out  8  packed data, {second nibble, first nibble}
byte_valid_o  out  1  byte_o valid
byte_ready_i  in  1  sink accepts byte_o
clr_stats_i  in  1  synchronous clear of statistics counters
frag_err_o  out  1  1-cycle pulse: partial codeword discarded by sof_i
cw_cnt_o  out  CNT_W  codewords decoded
corr_cnt_o  out  CNT_W  codewords with a data bit corrected
par_cnt_o  out  CNT_W  codewords with a parity-bit-only error

Behaviour:
- Reset (rst_n=0 at clock edge): state IDLE, bit_cnt=0, nibble-pending flag=0, byte_o=0, byte_valid_o=0, frag_err_o=0, all counters 0. Reset mid-codeword or mid-byte discards everything.
- Accept event: bit_valid_i & bit_ready_o. Bits arrive c0 first. Codeword bit order is c6..c0, with data d3..d0=c3..c0.
- FSM:
  - IDLE: bit_ready_o=1; bits without sof_i are dropped. An accepted bit with sof_i stores c0, sets bit_cnt=1, and goes to COLLECT.
  - COLLECT: each accepted bit is stored at index bit_cnt, then bit_cnt increments.
    - An accepted bit with sof_i and bit_cnt!=0 discards the partial codeword, pulses frag_err_o next cycle, and restarts with this bit as c0 (bit_cnt=1).
    - sof_i on the bit_cnt==0 position is legal, with no error.
    - Accepting the 7th bit (bit_cnt==6) completes the codeword in the same edge, sets bit_cnt=0, and stays in COLLECT.
- Decode (combinational on {bit_i, stored c5..c0} at completion):
  - Syndrome: s0=c4^c0^c1^c2, s1=c5^c0^c2^c3, s2=c6^c0^c1^c3.
  - s=111 flips d0; s=101 flips d1; s=011 flips d2; s=110 flips d3. Each of these increments corr_cnt.
  - s=001/010/100: data unchanged, par_cnt increments.
  - s=000: no change. Double errors are miscorrected silently, as the code allows.
  - cw_cnt increments on every completion.
- Packing:
  - First decoded nibble goes to the low-nibble register and sets pending.
  - Second nibble loads byte_o={nibble, low} with byte_valid_o=1 from the next cycle, and clears pending.
- Output handshake:
  - byte_o and byte_valid_o are held stable until byte_valid_o & byte_ready_i. At that edge byte_valid_o clears, unless a new byte loads in the same edge; then byte_valid_o stays 1 with the new data.
- Backpressure: bit_ready_o = 0 only when in COLLECT & bit_cnt==6 & pending & byte_valid_o & ~byte_ready_i; otherwise 1. This is a combinational path from byte_ready_i; no byte is ever lost or overwritten.
- Counters:
  - Saturate at all-ones.
  - clr_stats_i zeroes all counters. If it coincides with an increment, clear wins.
  - Counters are not affected by frag errors.
- Latency: last bit accepted at edge N means byte_valid_o is high in cycle N+1.

Test Plan:
- Clean stream: sof on cw 7'b1001011 (c6..c0), then 7'b1010010, sink ready → byte_o=8'h2B, byte_valid_o=1 one cycle after 14th bit; cw_cnt=2, corr_cnt=0, par_cnt=0.
- Data error: first cw sent as 7'b1001010 (c0 flipped, s=111) → byte_o still 8'h2B, corr_cnt=1.
- Parity error: second cw sent as 7'b1010010 with c5 flipped (7'b1110010, s=010) → byte_o=8'h2B, par_cnt=1, corr_cnt=0.
- Backpressure: byte_ready_i=0 while byte 8'h2B pending, stream a further two cws (data 4'h5, 4'hA) → bit_ready_o drops at the 14th bit of the second byte and holds; byte_o stays 8'h2B. Raising byte_ready_i → 8'h2B accepted, then 8'hA5 presented next cycle, with no bits lost.
- Resync: sof_i after 3 bits of a cw → frag_err_o 1-cycle pulse; the following 7 bits decode correctly; cw_cnt is unaffected by the fragment.
- Reset/clear: assert rst_n=0 mid-codeword → all outputs 0 next cycle and bits without sof ignored. Set counters to near all-ones with forced errors; saturate corr_cnt at 16'hFFFF; clr_stats_i with a simultaneous completion → counters read 0.
